hub75_receiver: RTL
===================

Name: hub75_receiver

Overview:
Panel-side endpoint of the HUB75 interface: samples the HUB75 lines produced by our driver (CK, LA, BL, A0-A4, R0/G0/B0, R1/G1/B1) and reconstructs pixel writes. Bits are shifted into a line buffer on CK rising edges. Each LA rising edge commits the line and drains it as a ready/valid pixel stream tagged with the panel row. The block is used as an in-fabric loopback monitor for the driver, feeding a frame-capture RAM or a checker.

Parameters:
COLS, 64, pixels shifted per line (power of two, 8..256); COL_W = log2(COLS) is derived
ADDR_W, 5, row-address width (A0..A4); the panel has 2**(ADDR_W+1) rows
SYNC_STAGES, 2, synchronizer depth applied to every hub_* input (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
hub_ck  in  1  HUB75 shift clock (asynchronous to clk)
hub_la  in  1  HUB75 latch
hub_bl  in  1  HUB75 blank/OE (1 = blanked)
hub_addr  in  ADDR_W  row address {A4..A0}
hub_rgb0  in  3  {R0,G0,B0}, upper half
hub_rgb1  in  3  {R1,G1,B1}, lower half
px_valid  out  1  pixel beat valid
px_ready  in  1  downstream accepts the beat
px_row  out  ADDR_W+1  {half, addr}; half=0 is upper
px_col  out  COL_W  column, 0 = first bit shifted in
px_rgb  out  3  {R,G,B}
line_done  out  1  one-cycle pulse after the last beat of a line is accepted
blank  out  1  synchronized hub_bl
err_overrun  out  1  sticky: latch arrived while the drain was busy
err_len  out  1  sticky: latched line had a shift count != COLS
err_clr  in  1  clears both sticky errors

Behaviour:
- Synchronization: all hub_* inputs pass through a SYNC_STAGES flop chain, so data stays aligned with CK/LA. Edge detection compares the last synchronizer stage with one extra register. An input edge is acted on SYNC_STAGES+1 clk edges after it is first sampled.
- Input timing: hub_ck high and low times must each be >= SYNC_STAGES+1 clk periods. Data and addr must be stable for >= 1 clk before the CK or LA rising edge; otherwise the behaviour is undefined.
- Shift side: buffer A holds COLS entries of 6 bits plus a counter shcnt of width COL_W+1. On a CK rising edge with shcnt < COLS, {rgb0,rgb1} is written to A[shcnt] and shcnt increments. Edges with shcnt == COLS are ignored and set a long flag.
- Latch, drain idle: on an LA rising edge, A is copied to drain buffer B and the synchronized addr is captured. If shcnt != COLS or the long flag is set, err_len is set; missing columns drain as 3'b000. shcnt and long are then cleared. The drain starts on the next cycle.
- Latch, drain busy: B is untouched and err_overrun is set. A, shcnt and long are still cleared, so the new line is dropped.
- Simultaneous CK and LA rise in the same cycle: the latch is applied first, then the shift, so the bit becomes column 0 of the next line.
- Drain FSM states: IDLE, UPPER, LOWER, DONE.
  - UPPER emits col 0..COLS-1 with px_row = {0,addr} and rgb = B[col][5:3].
  - LOWER emits the same columns with px_row = {1,addr} and rgb = B[col][2:0].
  - A beat transfers when px_valid && px_ready. The col counter advances only on a transfer and wraps to 0 on the UPPER->LOWER transition.
  - After the last LOWER transfer the FSM enters DONE: line_done = 1 for one cycle, then IDLE.
  - px_* stay stable while px_valid && !px_ready. px_valid is never dropped without a transfer.
- Throughput: 1 beat/clk when px_ready is held high, so a line takes 2*COLS cycles. Latency from the latch edge being acted on to the first px_valid is 1 cycle.
- blank: pass-through of the synchronized hub_bl, with no effect on capture.
- err_clr: clears both sticky errors. If it coincides with a new error event, the error wins.
- Reset (rst_n=0 at a clk edge): synchronizers = 0, the edge-detect registers load 0 (so a high input after reset is seen as a rising edge), shcnt = 0, FSM = IDLE. Outputs: px_valid = 0, px_row = 0, px_col = 0, px_rgb = 0, line_done = 0, blank = 0, err_* = 0. Reset mid-drain aborts the line with no line_done. Buffer contents are not reset.

Test Plan:
- Nominal line: COLS=64, CK period 8 clk. Shift col k with rgb0=k[2:0], rgb1=~k[2:0], addr=5'd9, then LA. Response with px_ready=1: 128 beats; rows 9 then 41; beat (row 9, col 10) rgb=3'b010; beat (row 41, col 10) rgb=3'b101; line_done pulses once; no errors.
- Backpressure: same line with px_ready toggling 1-0-0-1. Response: beat sequence identical; px_* held stable during stalls; 128 transfers total.
- Short/long line: latch after 60 CK edges. Response: err_len=1; cols 60..63 rgb=0. Then 70 edges plus LA: err_len stays 1; cols 0..63 hold the first 64 bits; then err_clr=1 -> err_len=0.
- Overrun: hold px_ready=0, latch line 1, shift and latch line 2. Response: err_overrun=1. Release px_ready: only line 1 (its addr and data) drains. Line 3 afterwards drains correctly.
- Coincident CK+LA: same-cycle rising edges on line 63. Response: the latched line has 63 columns and err_len=1; the bit appears as col 0 of the next line.
- Reset mid-drain: assert rst_n=0 for 1 cycle at beat 40. Response: next cycle px_valid=0, no line_done, err_*=0. A fresh line then drains fully from col 0.

Source files
------------

// File: rtl/hub75_receiver.sv
`default_nettype none
// ============================================================================
// Module      : hub75_receiver
// Description : HUB75 panel-side loopback monitor. Rebuilds latched lines and
//               drains them as a row-tagged ready/valid pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_receiver #(
    parameter int COLS        = 64,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2,
    localparam int COL_W      = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hub_ck,
    input  logic              hub_la,
    input  logic              hub_bl,
    input  logic [ADDR_W-1:0] hub_addr,
    input  logic [2:0]        hub_rgb0,
    input  logic [2:0]        hub_rgb1,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [ADDR_W:0]   px_row,
    output logic [COL_W-1:0]  px_col,
    output logic [2:0]        px_rgb,
    output logic              line_done,
    output logic              blank,
    output logic              err_overrun,
    output logic              err_len,
    input  logic              err_clr
);

    localparam int               c_SYNC_W  = ADDR_W + 9;
    localparam logic [COL_W:0]   c_FULL    = (COL_W+1)'(COLS);
    localparam logic [COL_W:0]   c_SH_ONE  = (COL_W+1)'(1);
    localparam logic [COL_W-1:0] c_LAST    = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] c_COL_ONE = COL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UPPER = 2'd1,
        S_LOWER = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [c_SYNC_W-1:0] w_hubIn;
    logic [c_SYNC_W-1:0] r_sync [SYNC_STAGES];
    logic                w_syncCk, w_syncLa;
    logic [ADDR_W-1:0]   w_syncAddr;
    logic [5:0]          w_syncRgb;
    logic                r_ckPrev, r_laPrev;
    logic                w_ckRise, w_laRise;

    logic [5:0]          r_bufA [COLS];
    logic [5:0]          r_bufB [COLS];
    logic [COL_W:0]      r_shcnt, w_shBase;
    logic                r_long, w_longBase;
    logic [ADDR_W-1:0]   r_lineAddr;
    logic                r_errOverrun, r_errLen;

    state_t              r_state, w_stateNext;
    logic [COL_W-1:0]    r_col, w_colNext;
    logic                w_drainIdle;

    // Every line goes through the same chain so CK/LA stay aligned with data.
    assign w_hubIn = {hub_ck, hub_la, hub_bl, hub_addr, hub_rgb0, hub_rgb1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_ckPrev <= 1'b0;
            r_laPrev <= 1'b0;
        end else begin
            r_sync[0] <= w_hubIn;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_ckPrev <= w_syncCk;
            r_laPrev <= w_syncLa;
        end
    end

    assign w_syncCk   = r_sync[SYNC_STAGES-1][c_SYNC_W-1];
    assign w_syncLa   = r_sync[SYNC_STAGES-1][c_SYNC_W-2];
    assign blank      = r_sync[SYNC_STAGES-1][c_SYNC_W-3];
    assign w_syncAddr = r_sync[SYNC_STAGES-1][6 +: ADDR_W];
    assign w_syncRgb  = r_sync[SYNC_STAGES-1][5:0];
    assign w_ckRise   = w_syncCk & ~r_ckPrev;
    assign w_laRise   = w_syncLa & ~r_laPrev;

    assign w_drainIdle = (r_state == S_IDLE);
    // A coincident latch clears the shift state before the shift is applied.
    assign w_shBase    = w_laRise ? '0 : r_shcnt;
    assign w_longBase  = w_laRise ? 1'b0 : r_long;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shcnt      <= '0;
            r_long       <= 1'b0;
            r_lineAddr   <= '0;
            r_errOverrun <= 1'b0;
            r_errLen     <= 1'b0;
        end else begin
            if (err_clr) begin
                r_errOverrun <= 1'b0;
                r_errLen     <= 1'b0;
            end
            if (w_laRise) begin
                if (w_drainIdle) begin
                    r_lineAddr <= w_syncAddr;
                    if (r_shcnt != c_FULL || r_long) r_errLen <= 1'b1;
                end else begin
                    r_errOverrun <= 1'b1;
                end
            end
            r_shcnt <= (w_ckRise && w_shBase != c_FULL) ? w_shBase + c_SH_ONE : w_shBase;
            r_long  <= w_longBase | (w_ckRise && w_shBase == c_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_ckRise && w_shBase != c_FULL) r_bufA[w_shBase[COL_W-1:0]] <= w_syncRgb;
            if (w_laRise && w_drainIdle) begin
                for (int i = 0; i < COLS; i++)
                    r_bufB[i] <= ((COL_W+1)'(i) < r_shcnt) ? r_bufA[i] : 6'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_col   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_col   <= w_colNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_colNext   = r_col;
        px_valid    = 1'b0;
        px_row      = '0;
        px_rgb      = 3'd0;
        line_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_laRise) begin
                    w_stateNext = S_UPPER;
                    w_colNext   = '0;
                end
            end
            S_UPPER: begin
                px_valid = 1'b1;
                px_row   = {1'b0, r_lineAddr};
                px_rgb   = r_bufB[r_col][5:3];
                if (px_ready) begin
                    if (r_col == c_LAST) begin
                        w_stateNext = S_LOWER;
                        w_colNext   = '0;
                    end else begin
                        w_colNext = r_col + c_COL_ONE;
                    end
                end
            end
            S_LOWER: begin
                px_valid = 1'b1;
                px_row   = {1'b1, r_lineAddr};
                px_rgb   = r_bufB[r_col][2:0];
                if (px_ready) begin
                    if (r_col == c_LAST) begin
                        w_stateNext = S_DONE;
                        w_colNext   = '0;
                    end else begin
                        w_colNext = r_col + c_COL_ONE;
                    end
                end
            end
            S_DONE: begin
                line_done   = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    assign px_col      = r_col;
    assign err_overrun = r_errOverrun;
    assign err_len     = r_errLen;

endmodule
`default_nettype wire
